conv1x1_frame_sequencer: RTL and testbench

Frame-level controller for the 12-channel 1x1 convolution datapath. On a start pulse it clears the datapath, then streams one feature-map frame (IMG_Width*IMG_Height pixels) from the 12 per-channel input buffers using a shared read address. It collects the datapath's result strobes, generates output-buffer write addresses, and reports done or timeout. It sits between the layer scheduler and the conv datapath/buffers.

---
 rtl/conv1x1_frame_sequencer.sv | 171 +++++++++++++++++
 tb/tb_conv1x1_frame_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1x1_frame_sequencer.sv
// conv1x1_frame_sequencer
// Frame-level controller for the 12-channel 1x1 convolution datapath.
// A start pulse clears the datapath, then one frame of IMG_Width*IMG_Height
// pixels is read from the channel input buffers through a shared address.
// Result strobes from the datapath are turned into output-buffer writes.
// The frame ends with a done pulse, or with err set if results stop arriving.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start             frame start request, honoured only in IDLE
//   abort             cancel the current frame, honoured only while busy
//   src_ready         input buffers hold data; low suspends read issue
//   rd_en, rd_addr    read strobe and shared pixel address to the input buffers
//   conv_valid_in     rd_en delayed one cycle (one-cycle buffer read latency)
//   conv_clr          one-cycle datapath clear pulse
//   conv_valid_out    result strobe from the datapath
//   wr_en, wr_addr    output-buffer write strobe and address (combinational)
//   busy              frame in progress (CLEAR, ISSUE, DRAIN)
//   done              one-cycle frame-complete pulse
//   err               sticky timeout flag, cleared by the next accepted start
//   fsm_state         current state: 0 IDLE, 1 CLEAR, 2 ISSUE, 3 DRAIN, 4 DONE
//
// Handshake: a read is issued on every cycle rd_en is high; its data reaches
// the datapath one cycle later, flagged by conv_valid_in. Every cycle that
// conv_valid_out is high while the frame is collecting results and fewer than
// N results have been written produces exactly one write (wr_en high).
module conv1x1_frame_sequencer #(
    parameter int IMG_Width  = 3,
    parameter int IMG_Height = 3,
    parameter int ADDR_W     = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              src_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              conv_valid_in,
    output logic              conv_clr,
    input  logic              conv_valid_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        fsm_state
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int IDLE_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  N_C       = CNT_W'(IMG_Width * IMG_Height);
    localparam logic [CNT_W-1:0]  N_LAST    = CNT_W'(IMG_Width * IMG_Height - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   res_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [CNT_W-1:0]   res_next;
    logic               in_frame;

    assign fsm_state = state;
    assign in_frame  = (state == S_CLEAR) || (state == S_ISSUE) || (state == S_DRAIN);

    // Writes follow the registered datapath output directly so no result
    // strobe is lost; anything past N or outside ISSUE/DRAIN is dropped.
    assign wr_en    = conv_valid_out && ((state == S_ISSUE) || (state == S_DRAIN))
                      && (res_cnt < N_C);
    assign wr_addr  = res_cnt[ADDR_W-1:0];
    assign res_next = res_cnt + CNT_W'(wr_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            rd_en         <= 1'b0;
            rd_addr       <= '0;
            conv_valid_in <= 1'b0;
            conv_clr      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            issue_cnt     <= '0;
            res_cnt       <= '0;
            idle_cnt      <= '0;
        end else begin
            conv_valid_in <= rd_en;
            conv_clr      <= 1'b0;
            done          <= 1'b0;
            res_cnt       <= res_next;

            if (abort && in_frame) begin
                // Abort wins over every other transition of this cycle.
                state    <= S_IDLE;
                conv_clr <= 1'b1;
                rd_en    <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        rd_en <= 1'b0;
                        if (start) begin
                            state     <= S_CLEAR;
                            conv_clr  <= 1'b1;
                            busy      <= 1'b1;
                            err       <= 1'b0;
                            rd_addr   <= '0;
                            issue_cnt <= '0;
                            res_cnt   <= '0;
                            idle_cnt  <= '0;
                        end
                    end
                    S_CLEAR: begin
                        rd_en <= 1'b0;
                        state <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        if (src_ready && (issue_cnt < N_C)) begin
                            rd_en     <= 1'b1;
                            rd_addr   <= issue_cnt[ADDR_W-1:0];
                            issue_cnt <= issue_cnt + CNT_W'(1);
                            if (issue_cnt == N_LAST) begin
                                state <= S_DRAIN;
                            end
                        end else begin
                            // Stall: address stays on the last issued pixel.
                            rd_en <= 1'b0;
                        end
                    end
                    S_DRAIN: begin
                        rd_en <= 1'b0;
                        if (res_next == N_C) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (!conv_valid_out) begin
                            if (idle_cnt == IDLE_LAST) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                err   <= 1'b1;
                            end else begin
                                idle_cnt <= idle_cnt + IDLE_W'(1);
                            end
                        end else begin
                            idle_cnt <= '0;
                        end
                    end
                    S_DONE: begin
                        rd_en <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        rd_en <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv1x1_frame_sequencer.sv
// Testbench for conv1x1_frame_sequencer: 3x3 frame, TIMEOUT 8.
// The stimulus process drives inputs on the falling edge and acts as a datapath
// that echoes conv_valid_in one cycle later for a chosen number of results.
// Expected reads, writes and done events are queued as frames are issued;
// the monitor samples just after the falling edge and pops on every event.
module tb_conv1x1_frame_sequencer;

    localparam int IMG_W   = 3;
    localparam int IMG_H   = 3;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 8;
    localparam int N       = IMG_W * IMG_H;

    // clock / reset
    logic clk            = 1'b0;
    logic rst            = 1'b1;
    logic start          = 1'b0;
    logic abort          = 1'b0;
    logic src_ready      = 1'b0;
    logic conv_valid_out = 1'b0;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              conv_valid_in;
    logic              conv_clr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        fsm_state;

    always #5 clk = ~clk;

    conv1x1_frame_sequencer #(
        .IMG_Width (IMG_W),
        .IMG_Height(IMG_H),
        .ADDR_W    (ADDR_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .src_ready     (src_ready),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .conv_valid_in (conv_valid_in),
        .conv_clr      (conv_clr),
        .conv_valid_out(conv_valid_out),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .fsm_state     (fsm_state)
    );

    // scoreboard
    logic [ADDR_W-1:0] exp_rd_q[$];
    logic [ADDR_W-1:0] exp_wr_q[$];
    logic [0:0]        exp_err_q[$];
    logic [15:0]       exp_lat_q[$];

    int   n_checks      = 0;
    int   n_pass        = 0;
    int   exp_frames    = 0;
    int   exp_abort_clr = 0;
    int   seen_frames   = 0;
    int   seen_abort    = 0;
    bit   end_req       = 1'b0;

    int   echo_left     = 0;
    logic echo_pipe     = 1'b0;

    logic        prev_rd_en = 1'b0;
    bit          rst_prev   = 1'b1;
    int          mcyc       = 0;
    int          clr_cyc    = 0;
    logic [31:0] exp_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got event value %0h, expected no event", name, act);
    endtask

    // driver: one falling edge; also runs the echoing datapath model
    task automatic step(input bit st, input bit ab, input bit sr, input bit spur, input bit r);
        @(negedge clk);
        start     = st;
        abort     = ab;
        src_ready = sr;
        rst       = r;
        conv_valid_out = (echo_pipe && echo_left > 0) || spur;
        if (echo_pipe && echo_left > 0) echo_left--;
        echo_pipe = conv_valid_in;
    endtask

    task automatic idle_gap();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);   // abort while idle has no effect
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One frame. Cycle 0 is the CLEAR cycle; reads happen in ISSUE cycles with
    // src_ready high; each read's result returns three cycles after its ISSUE
    // cycle. m = results the datapath delivers.
    task automatic run_frame(input int m, input int stall, input int abort_after,
                             input bit do_rst, input bit noise);
        int k, reads, i, lat, drain_start, first_idle;
        int rd_j[$];
        bit sr, ab, st, nz;
        echo_left = m;
        for (int w = 0; w < ((m < N) ? m : N); w++) exp_wr_q.push_back(ADDR_W'(w));
        exp_frames++;
        step(1'b1, noise, 1'b0, 1'b0, 1'b0);   // start (with abort in noise frame)
        step(1'b0, 1'b0, 1'b0, noise, 1'b0);   // CLEAR cycle, spurious strobe in noise frame
        k = 2;
        reads = 0;
        while (reads < N) begin
            i = k - 2;
            case (stall)
                0:       sr = 1'b1;
                1:       sr = !(i >= 3 && i <= 5);
                default: sr = ($urandom_range(0, 9) < 7);
            endcase
            ab = (abort_after > 0) && (reads == abort_after);
            st = noise && (i == 3);
            step(st, ab, sr, 1'b0, 1'b0);
            if (ab) begin
                exp_abort_clr++;
                repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (sr) begin
                exp_rd_q.push_back(ADDR_W'(reads));
                rd_j.push_back(k - 1);
                reads++;
            end
            k++;
        end
        drain_start = rd_j[N-1] + 1;
        if (do_rst) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            repeat (TIMEOUT + 6) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        if (m >= N) begin
            lat = rd_j[N-1] + 4;
        end else begin
            first_idle = drain_start;
            if (m > 0 && rd_j[m-1] + 4 > first_idle) first_idle = rd_j[m-1] + 4;
            lat = first_idle + TIMEOUT;
        end
        exp_err_q.push_back(m < N);
        exp_lat_q.push_back(16'(lat));
        for (int idx = k; idx <= lat + 1; idx++) begin
            nz = noise && (idx == lat + 1);   // start and strobe during DONE
            step(nz, 1'b0, 1'b0, nz, 1'b0);
        end
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // stimulus
    initial begin : stimulus
        int m;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(N, 0, 0, 1'b0, 1'b0); idle_gap();   // nominal
        run_frame(N, 1, 0, 1'b0, 1'b0); idle_gap();   // src_ready gap
        run_frame(5, 0, 0, 1'b0, 1'b0); idle_gap();   // timeout after 5 results
        run_frame(N, 0, 0, 1'b0, 1'b0); idle_gap();   // err cleared by new start
        run_frame(0, 0, 4, 1'b0, 1'b0); idle_gap();   // abort after 4 reads
        run_frame(N, 0, 0, 1'b0, 1'b0); idle_gap();   // clean frame after abort
        run_frame(N, 0, 0, 1'b0, 1'b1); idle_gap();   // spurious strobes, extra starts
        run_frame(0, 0, 0, 1'b1, 1'b0); idle_gap();   // reset mid-DRAIN
        for (int f = 0; f < 5; f++) begin
            m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : N;
            run_frame(m, 2, 0, 1'b0, 1'b0);
            idle_gap();
        end
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end_req = 1'b1;
    end

    // monitor
    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            mcyc++;
            if (rst_prev) begin
                check("reset_outputs",
                      32'({rd_en, rd_addr, conv_valid_in, conv_clr, busy, done, err,
                           wr_en, wr_addr, fsm_state}), 32'(0));
            end else begin
                check("valid_in_align", 32'(conv_valid_in), 32'(prev_rd_en));
                if (rd_en) begin
                    if (exp_rd_q.size() == 0) unexpected("rd_extra", 32'(rd_addr));
                    else begin
                        exp_v = 32'(exp_rd_q.pop_front());
                        check("rd_addr", 32'(rd_addr), exp_v);
                    end
                end
                if (wr_en) begin
                    if (exp_wr_q.size() == 0) unexpected("wr_extra", 32'(wr_addr));
                    else begin
                        exp_v = 32'(exp_wr_q.pop_front());
                        check("wr_addr", 32'(wr_addr), exp_v);
                    end
                end
                if (conv_clr && busy) begin
                    clr_cyc = mcyc;
                    seen_frames++;
                    check("err_cleared_on_start", 32'(err), 32'(0));
                end
                if (conv_clr && !busy) seen_abort++;
                if (done) begin
                    if (exp_err_q.size() == 0) unexpected("done_extra", 32'(err));
                    else begin
                        exp_v = 32'(exp_err_q.pop_front());
                        check("done_err", 32'(err), exp_v);
                        exp_v = 32'(exp_lat_q.pop_front());
                        check("done_latency", 32'(mcyc - clr_cyc), exp_v);
                        check("done_busy_low", 32'(busy), 32'(0));
                    end
                end
            end
            prev_rd_en = rd_en;
            rst_prev   = rst;
            if (end_req) begin
                check("reads_outstanding",  32'(exp_rd_q.size()),  32'(0));
                check("writes_outstanding", 32'(exp_wr_q.size()),  32'(0));
                check("dones_outstanding",  32'(exp_err_q.size()), 32'(0));
                check("frames_started",     32'(seen_frames),      32'(exp_frames));
                check("abort_clears",       32'(seen_abort),       32'(exp_abort_clr));
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $finish;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
